// File: rtl/pp_run_ctrl_pkg.sv
// Shared types and helpers for the pp run controller: FSM states, termination
// cause encodings and a width-generic saturating increment.
package pp_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } runState_t;

  typedef logic [2:0] status_t;

  localparam status_t ST_NONE    = 3'd0;
  localparam status_t ST_HALT    = 3'd1;
  localparam status_t ST_TOHOST  = 3'd2;
  localparam status_t ST_STUCK   = 3'd3;
  localparam status_t ST_TIMEOUT = 3'd4;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] satInc(input logic [63:0] v, input int unsigned w);
    logic [63:0] maxV;
    maxV = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= maxV) ? maxV : v + 64'd1;
  endfunction

endpackage

// File: rtl/pp_run_ctrl_if.sv
// Bundle between the bench/top level and the run controller: start request,
// core observation signals, and the controller's status/counter outputs.
interface pp_run_ctrl_if
  import pp_run_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] iaddr;
  logic              pcHold;
  logic              dWr;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dwData;
  logic              coreRstN;
  logic              runEn;
  logic              busy;
  logic              done;
  status_t           status;
  logic [ADDR_W-1:0] exitCode;
  logic [CNT_W-1:0]  cycleCnt;
  logic [CNT_W-1:0]  stallCnt;

  modport master (
    output start, iaddr, pcHold, dWr, daddr, dwData,
    input  coreRstN, runEn, busy, done, status, exitCode, cycleCnt, stallCnt
  );

  modport slave (
    input  start, iaddr, pcHold, dWr, daddr, dwData,
    output coreRstN, runEn, busy, done, status, exitCode, cycleCnt, stallCnt
  );
endinterface

// File: rtl/pp_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import pp_run_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, park at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(satInc(64'(q), W));
    end
  end

endmodule

// File: rtl/pp_run_ctrl.sv
// Run controller for the pp core: sequences core reset, gates the core clock
// enable, detects termination (tohost, halt, stuck PC, timeout), drains the
// pipeline and reports cause, exit code and performance counters.
module pp_run_ctrl
  import pp_run_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              CNT_W        = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = 'h48,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'hFFF0,
  parameter int              RST_CYCLES   = 4,
  parameter int              DRAIN_CYCLES = 4,
  parameter int              STUCK_LIMIT  = 64,
  parameter int              TIMEOUT      = 100000
) (
  input logic          clk,
  input logic          rst,
  pp_run_ctrl_if.slave bus
);

  runState_t         state;
  logic [CNT_W-1:0]  rstCnt;
  logic [CNT_W-1:0]  drnCnt;
  logic [ADDR_W-1:0] lastPc;
  logic [ADDR_W-1:0] exitCodeQ;
  status_t           statusQ;
  logic              coreRstNQ;
  logic              runEnQ;
  logic              busyQ;
  logic              doneQ;

  logic [CNT_W-1:0]  cycleCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  stuckCnt;

  logic              startRun;
  logic              inRun;
  logic              pcSame;
  logic              hitTohost;
  logic              hitHalt;
  logic              hitStuck;
  logic              hitTimeout;
  status_t           termCause;

  assign startRun   = ((state == IDLE) || (state == DONE)) && bus.start;
  assign inRun      = (state == RUN);
  assign pcSame     = (bus.iaddr == lastPc);
  assign hitTohost  = bus.dWr && (bus.daddr == TOHOST_ADDR);
  assign hitHalt    = (bus.iaddr >= HALT_ADDR);
  assign hitStuck   = (stuckCnt == CNT_W'(STUCK_LIMIT - 1)) && pcSame;
  // >= so a counter parked at saturation still reports the timeout.
  assign hitTimeout = (cycleCnt >= CNT_W'(TIMEOUT - 1));

  // Pick the single highest-priority termination cause for this cycle.
  always_comb begin
    termCause = ST_NONE;
    if (hitTohost) begin
      termCause = ST_TOHOST;
    end else if (hitHalt) begin
      termCause = ST_HALT;
    end else if (hitStuck) begin
      termCause = ST_STUCK;
    end else if (hitTimeout) begin
      termCause = ST_TIMEOUT;
    end
  end

  sat_counter #(.W(CNT_W)) uCycleCnt (
    .clk (clk),
    .rst (rst),
    .clr (startRun),
    .inc ((state == RUN) || (state == DRAIN)),
    .q   (cycleCnt)
  );

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .clr (startRun),
    .inc (inRun && bus.pcHold),
    .q   (stallCnt)
  );

  sat_counter #(.W(CNT_W)) uStuckCnt (
    .clk (clk),
    .rst (rst),
    .clr (startRun || (inRun && !pcSame)),
    .inc (inRun && pcSame),
    .q   (stuckCnt)
  );

  // Run sequencing FSM; every output is a register updated with its next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rstCnt    <= '0;
      drnCnt    <= '0;
      lastPc    <= '0;
      statusQ   <= ST_NONE;
      exitCodeQ <= '0;
      coreRstNQ <= 1'b0;
      runEnQ    <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= RESET;
            rstCnt    <= CNT_W'(RST_CYCLES - 1);
            lastPc    <= '0;
            statusQ   <= ST_NONE;
            exitCodeQ <= '0;
            coreRstNQ <= 1'b0;
            runEnQ    <= 1'b1;
            busyQ     <= 1'b1;
            doneQ     <= 1'b0;
          end
        end
        RESET: begin
          if (rstCnt == '0) begin
            state     <= RUN;
            coreRstNQ <= 1'b1;
          end else begin
            rstCnt <= rstCnt - 1'b1;
          end
        end
        RUN: begin
          lastPc <= bus.iaddr;
          if (termCause != ST_NONE) begin
            statusQ <= termCause;
            if (termCause == ST_TOHOST) begin
              exitCodeQ <= bus.dwData;
            end
            drnCnt <= CNT_W'(DRAIN_CYCLES);
            if (DRAIN_CYCLES == 0) begin
              state  <= DONE;
              runEnQ <= 1'b0;
              busyQ  <= 1'b0;
              doneQ  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drnCnt <= CNT_W'(1)) begin
            state  <= DONE;
            runEnQ <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
          end else begin
            drnCnt <= drnCnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.coreRstN = coreRstNQ;
  assign bus.runEn    = runEnQ;
  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;
  assign bus.status   = statusQ;
  assign bus.exitCode = exitCodeQ;
  assign bus.cycleCnt = cycleCnt;
  assign bus.stallCnt = stallCnt;

endmodule

// File: tb/tb_pp_run_ctrl.sv
// Directed bench for pp_run_ctrl: reset/start sequencing, each termination
// cause, priority, drain behaviour, restart and asynchronous abort.
module tb_pp_run_ctrl;
  import pp_run_pkg::*;

  localparam int RST_CYC = 4;
  localparam int DRN_CYC = 4;

  typedef struct {
    logic [2:0]  status;
    logic [31:0] exitCode;
    logic [31:0] cycles;
    logic [31:0] stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  pp_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  pp_run_ctrl #(
    .ADDR_W       (32),
    .CNT_W        (32),
    .HALT_ADDR    (32'h48),
    .TOHOST_ADDR  (32'hFFF0),
    .RST_CYCLES   (RST_CYC),
    .DRAIN_CYCLES (DRN_CYC),
    .STUCK_LIMIT  (8),
    .TIMEOUT      (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input logic [31:0] ia, input logic ph, input logic wr,
                          input logic [31:0] da, input logic [31:0] wd);
    bus.iaddr  = ia;
    bus.pcHold = ph;
    bus.dWr    = wr;
    bus.daddr  = da;
    bus.dwData = wd;
    step();
  endtask

  task automatic startRun();
    bus.iaddr  = '0;
    bus.pcHold = 1'b0;
    bus.dWr    = 1'b0;
    bus.daddr  = '0;
    bus.dwData = '0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    check("startBusy", bus.busy, 1);
    check("startDone", bus.done, 0);
    check("startCoreRst", bus.coreRstN, 0);
    check("startRunEn", bus.runEn, 1);
    check("startCycleClr", bus.cycleCnt, 0);
    check("startStatusClr", bus.status, ST_NONE);
    for (int k = 1; k < RST_CYC; k++) begin
      step();
      check("rstLow", bus.coreRstN, 0);
    end
    step();
    check("runEntry", bus.coreRstN, 1);
  endtask

  task automatic finishRun();
    int   n;
    exp_t e;
    n = 0;
    while (!bus.done && n < 40) begin
      step();
      n++;
    end
    check("drainLatency", n, DRN_CYC);
    check("sbNonEmpty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("endStatus", bus.status, e.status);
      check("endExitCode", bus.exitCode, e.exitCode);
      check("endCycleCnt", bus.cycleCnt, e.cycles);
      check("endStallCnt", bus.stallCnt, e.stalls);
    end
    check("doneRunEn", bus.runEn, 0);
    check("doneCoreRst", bus.coreRstN, 1);
    check("doneBusy", bus.busy, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.iaddr  = '0;
    bus.pcHold = 1'b0;
    bus.dWr    = 1'b0;
    bus.daddr  = '0;
    bus.dwData = '0;
    step();
    step();
    check("rstCoreRst", bus.coreRstN, 0);
    check("rstRunEn", bus.runEn, 0);
    check("rstBusy", bus.busy, 0);
    check("rstDone", bus.done, 0);
    check("rstStatus", bus.status, 0);
    check("rstExitCode", bus.exitCode, 0);
    check("rstCycleCnt", bus.cycleCnt, 0);
    check("rstStallCnt", bus.stallCnt, 0);
    rst = 1'b0;
    repeat (5) step();
    check("idleBusy", bus.busy, 0);
    check("idleCoreRst", bus.coreRstN, 0);

    // HALT: 19 fetches 0..0x48, then 4 drain cycles.
    sb.push_back('{ST_HALT, 32'h0, 32'd23, 32'd0});
    startRun();
    for (int i = 0; i < 19; i++) begin
      runCycle(32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("haltStatus", bus.status, ST_HALT);
    check("haltBusy", bus.busy, 1);
    check("haltCycleCnt", bus.cycleCnt, 19);
    finishRun();

    // TOHOST beats HALT in the same cycle; a later store in DRAIN is ignored.
    sb.push_back('{ST_TOHOST, 32'h2A, 32'd7, 32'd2});
    startRun();
    runCycle(32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    runCycle(32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
    runCycle(32'h48, 1'b0, 1'b1, 32'hFFF0, 32'h2A);
    check("tohostStatus", bus.status, ST_TOHOST);
    check("tohostExit", bus.exitCode, 32'h2A);
    bus.dwData = 32'h55;
    finishRun();

    // STUCK: hold 0x10, change to 0x14 (count restarts, start ignored), hold 0x14.
    sb.push_back('{ST_STUCK, 32'h0, 32'd18, 32'd13});
    startRun();
    for (int i = 0; i < 5; i++) begin
      runCycle(32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    bus.start = 1'b1;
    runCycle(32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.start = 1'b0;
    check("startInRunBusy", bus.busy, 1);
    check("startInRunCoreRst", bus.coreRstN, 1);
    for (int i = 0; i < 7; i++) begin
      runCycle(32'h14, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    check("stuckNotYet", bus.status, ST_NONE);
    runCycle(32'h14, 1'b1, 1'b0, 32'h0, 32'h0);
    check("stuckStatus", bus.status, ST_STUCK);
    finishRun();

    // TIMEOUT at the 20th RUN cycle with fetches kept below HALT_ADDR.
    sb.push_back('{ST_TIMEOUT, 32'h0, 32'd24, 32'd7});
    startRun();
    for (int i = 0; i < 19; i++) begin
      runCycle(32'((i % 16) * 4), (i % 3) == 0, 1'b0, 32'h0, 32'h0);
    end
    check("timeoutNotYet", bus.status, ST_NONE);
    check("timeoutPreCnt", bus.cycleCnt, 19);
    runCycle(32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    check("timeoutStatus", bus.status, ST_TIMEOUT);
    check("timeoutCycleCnt", bus.cycleCnt, 20);
    finishRun();

    // Asynchronous reset between edges while draining.
    startRun();
    runCycle(32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
    check("abortPreStatus", bus.status, ST_HALT);
    step();
    check("abortPreBusy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abortCoreRst", bus.coreRstN, 0);
    check("abortRunEn", bus.runEn, 0);
    check("abortBusy", bus.busy, 0);
    check("abortDone", bus.done, 0);
    check("abortStatus", bus.status, 0);
    check("abortCycleCnt", bus.cycleCnt, 0);
    rst = 1'b0;
    repeat (3) step();
    check("abortIdleBusy", bus.busy, 0);
    check("abortIdleCoreRst", bus.coreRstN, 0);
    check("sbDrained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_run_ctrl.md
Name: pp_run_ctrl

Overview:
- Synthesizable run controller for the pipelined processor `pp`. It replaces ad-hoc bench clock gating with a parametrised block.
- It sequences core reset and gates the core clock enable. It detects program termination by four causes: halt address, tohost store, stuck PC, or timeout.
- After termination it drains the pipeline, then reports status, exit code and performance counters.
- It sits between the bench/top level and the `pp`/`imem`/`dmem` instance.

Parameters:
ADDR_W, 32, width of iaddr/daddr/dwData
CNT_W, 32, width of all counters
HALT_ADDR, 32'h48, fetch address at or above which the program is complete
TOHOST_ADDR, 32'hFFF0, data address whose store terminates the run
RST_CYCLES, 4, cycles coreRstN is held low (minimum 1)
DRAIN_CYCLES, 4, cycles the core keeps running after termination (0 allowed)
STUCK_LIMIT, 64, consecutive RUN cycles with unchanged iaddr that count as a hang
TIMEOUT, 100000, RUN cycles before forced termination

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse that begins a run
iaddr  in  ADDR_W  core fetch address
pcHold  in  1  core PC stall indicator
dWr  in  1  core data-memory write enable
daddr  in  ADDR_W  core data address
dwData  in  ADDR_W  core store data
coreRstN  out  1  active-low reset to the core (drives regRst/pcRst)
runEn  out  1  core clock enable
busy  out  1  high in RESET, RUN and DRAIN
done  out  1  high in DONE
status  out  3  termination cause: 0 none, 1 HALT, 2 TOHOST, 3 STUCK, 4 TIMEOUT
exitCode  out  ADDR_W  dwData captured on the tohost store, else 0
cycleCnt  out  CNT_W  RUN+DRAIN cycles executed
stallCnt  out  CNT_W  RUN cycles with pcHold=1

Behaviour:
- **Reset values (rst=1, asynchronous):**
  - state IDLE, coreRstN=0, runEn=0, busy=0, done=0, status=0, exitCode=0.
  - All counters 0, stuck counter 0, lastPc 0.
  - rst mid-run aborts immediately to these values.
- **FSM:** IDLE, RESET, RUN, DRAIN, DONE. All outputs are registered.
- **IDLE:**
  - coreRstN=0, runEn=0.
  - start=1 -> RESET. This entry clears counters, status and exitCode, and loads rstCnt=RST_CYCLES-1.
- **RESET:**
  - coreRstN=0, runEn=1, so the core resets synchronously too.
  - Decrement rstCnt; at 0 -> RUN. coreRstN is therefore low for exactly RST_CYCLES cycles after the start edge.
- **RUN:**
  - coreRstN=1, runEn=1.
  - Every cycle: cycleCnt+1; stallCnt+1 if pcHold.
  - iaddr==lastPc -> stuckCnt+1, else stuckCnt=0. lastPc<=iaddr.
  - Termination checks are evaluated each cycle on current inputs, in this priority order:
    - TOHOST: dWr && daddr==TOHOST_ADDR. Capture exitCode=dwData.
    - HALT: iaddr>=HALT_ADDR (unsigned).
    - STUCK: stuckCnt==STUCK_LIMIT-1 and iaddr==lastPc.
    - TIMEOUT: cycleCnt==TIMEOUT-1.
  - On the first termination event: latch status and load drnCnt=DRAIN_CYCLES. Go to DRAIN, or directly to DONE if DRAIN_CYCLES==0.
  - Simultaneous events latch only the highest-priority cause.
- **DRAIN:**
  - runEn=1; cycleCnt+1 per cycle.
  - Further terminations are ignored; status and exitCode are frozen.
  - Decrement drnCnt; at 1 -> DONE.
- **DONE:**
  - runEn=0, coreRstN=1, so core state is preserved for memory dumps. done=1.
  - start=1 -> RESET (restart, counters cleared).
- **start handling:** start in RESET, RUN or DRAIN is ignored.
- **Counters:** saturate at all-ones and never wrap. A saturated cycleCnt does not mask a TIMEOUT already reached.
- **busy** = state in {RESET, RUN, DRAIN}. done and busy are mutually exclusive.
- **Latency:** start -> busy=1 next edge. Termination event -> status valid next edge. done rises DRAIN_CYCLES+1 edges after the event.

Decomposition:
- Package `pp_run_pkg`:
  - state enum (IDLE..DONE).
  - status encodings ST_NONE, ST_HALT, ST_TOHOST, ST_STUCK, ST_TIMEOUT.
  - Saturating-increment function.
- One sub-module, `sat_counter` (params W; ports clk, rst, clr, inc, q). It is instantiated for cycleCnt, stallCnt and stuckCnt.
- FSM, termination priority logic and capture registers live in pp_run_ctrl.

Test Plan:
1. Reset/sequence: rst pulse, then start at cycle 10 -> coreRstN low cycles 11-14, RUN from 15, busy=1; before start all outputs at reset values.
2. HALT: feed iaddr 0,4,...,0x48 one per cycle with DRAIN_CYCLES=4 -> status=1, done rises 5 edges after iaddr=0x48, cycleCnt=19+4=23, runEn=0 in DONE.
3. TOHOST vs HALT simultaneous: dWr=1, daddr=0xFFF0, dwData=0x2A, iaddr=0x48 in the same cycle -> status=2, exitCode=0x2A.
4. STUCK with stalls: iaddr held at 0x10 with pcHold=1, STUCK_LIMIT=8 -> status=3 after 8 equal cycles; stallCnt=8; iaddr change at cycle 7 restarts the count.
5. TIMEOUT=20, iaddr increments forever below HALT_ADDR -> status=4 at cycleCnt=20; start in DONE restarts with counters 0; start during RUN ignored.
6. rst asserted mid-DRAIN (asynchronous, between edges) -> coreRstN=0, status=0, done=0, busy=0 immediately, state IDLE.
